pad_input_conditioner: RTL and testbench
========================================

# pad_input_conditioner

Parametrised pad-side conditioning block between the pad ring and the core. It contains two functions:
- A reset synchroniser with configurable depth and asynchronous assertion / synchronous deassertion.
- N channels of active-low input conditioning: synchroniser, debounce counter, and press/release pulse generation.

It replaces the hand-instantiated reset flop pair in the chip top. It also lets the button and sensor inputs (nMode, nTrip, nFork, nCrank) reach the core already clean.

## Interface
Parameters:
- N_CH, 4, number of conditioned input channels (≥1)
- SYNC_STAGES, 2, flop depth of the reset synchroniser and of each channel synchroniser (≥2)
- DEB_CYCLES, 16, consecutive stable synchronised cycles required to accept a level change (≥1); counter width is max(1, clog2(DEB_CYCLES))

Ports:
- Clock  in  1  single system clock; all flops are rising-edge.
- nReset  in  1  pad reset; asynchronous, active-low.
- nResetCore  out  1  synchronised core reset, active-low.
- nIn  in  N_CH  raw active-low pad inputs; asynchronous to Clock.
- Level  out  N_CH  debounced level; 1 = released, 0 = pressed.
- Press  out  N_CH  one-cycle pulse when a channel's debounced level falls 1→0.
- Release  out  N_CH  one-cycle pulse when a channel's debounced level rises 0→1.
- Test  in  1  DFT bypass; present only when TEST_BYPASS_EN is defined.

Reset is asynchronous, active-low, on nReset. All logic is clocked by Clock.

## Operation
Reset synchroniser:
- The chain has SYNC_STAGES flops, all asynchronously cleared by nReset.
- Stage 0 has D = 1. Stage i has D = stage i-1.
- nResetCore is the last stage.

Channel logic:
- All channel flops are asynchronously reset by nResetCore, not by the raw nReset.

Per channel c:
- A SYNC_STAGES-deep synchroniser on nIn[c] produces s. Its flops reset to 1.
- Stable register L resets to 1. Level[c] = L.
- Counter cnt resets to 0.
- Each cycle:
  - If s == L: cnt ← 0.
  - Else if cnt == DEB_CYCLES-1: L ← s and cnt ← 0. The Press or Release pulse is registered in the same edge: Press if s = 0, Release if s = 1.
  - Else: cnt ← cnt+1.
- A glitch that returns to L before acceptance clears cnt. Partial counts never accumulate across glitches.
- cnt never exceeds DEB_CYCLES-1, so no wrap-around is possible.
- Channels are fully independent. Simultaneous changes on any subset of channels each follow their own timing, and pulses may coincide.
- Press and Release on the same channel are mutually exclusive in any cycle.

Reset values:
- nResetCore = 0
- Level = all 1s
- Press = 0
- Release = 0

## Timing
- nReset falling: nResetCore goes to 0 immediately (asynchronous, no clock needed). All channel state clears at the same time.
- nReset rising before edge 1: nResetCore rises after edge SYNC_STAGES.
- Pad change before edge 1:
  - s changes after edge SYNC_STAGES.
  - Level changes and the pulse goes high after edge SYNC_STAGES+DEB_CYCLES.
  - The pulse stays high exactly one cycle.
- Reset mid-debounce: cnt and L return to their reset values. After nResetCore deasserts, a pad held low needs the full SYNC_STAGES+DEB_CYCLES again before Press.
- No output is combinational from nIn. Outputs are combinational from nReset only in the bypass case under TEST_BYPASS_EN.

## Configuration
TEST_BYPASS_EN:
- Defined:
  - The Test port exists.
  - While Test = 1, nResetCore = nReset combinationally, so the pad has direct control over reset for scan.
  - While Test = 1, the debounce threshold is treated as 1: L ← s on the first cycle s ≠ L, with the normal pulse.
  - While Test = 0, behaviour is identical to the undefined case.
- Undefined:
  - No Test port.
  - The synchroniser and debounce behave as specified above.

## Test plan
All scenarios use defaults: N_CH=4, SYNC_STAGES=2, DEB_CYCLES=16.
- Reset release: hold nReset=0 for 5 cycles, then release before edge 1 → nResetCore=0 through edge 1, =1 after edge 2. Level=4'b1111, Press=Release=0 throughout.
- Clean press: drive nIn[0]=0 before edge 1 and hold → Level[0] falls and Press[0]=1 after edge 18, Press[0]=0 after edge 19. Release then follows symmetrically.
- Glitch rejection: pulse nIn[1] low for 15 cycles, high for 1 cycle, low for 15 cycles → Level[1] stays 1 and Press[1] is never asserted.
- Simultaneous channels: drop nIn[3:0] to 0 at the same cycle → Press=4'b1111 for exactly one cycle, 18 edges later.
- Reset mid-debounce: hold nIn[2]=0 for 10 cycles, pulse nReset low, release → Press[2] is asserted 18 edges after nResetCore rises, not earlier.
- TEST_BYPASS_EN, Test=1: nReset toggles → nResetCore follows the same cycle. nIn[0] low → Press[0] after edge 3.

Source files
------------

// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner
//   Pad-side conditioning between the pad ring and the core:
//   - reset synchroniser (async assert, sync deassert) producing nResetCore
//   - N_CH active-low input channels, each with a synchroniser, a debounce
//     counter and registered press/release pulses
//
// Ports:
//   Clock       in   system clock, rising edge
//   nReset      in   pad reset, asynchronous, active-low
//   nResetCore  out  synchronised core reset, active-low
//   nIn         in   raw active-low pad inputs (asynchronous to Clock)
//   Level       out  debounced level, 1 = released, 0 = pressed
//   Press       out  one-cycle pulse on debounced 1->0
//   Release     out  one-cycle pulse on debounced 0->1
//   Test        in   DFT bypass, present only when TEST_BYPASS_EN is defined
//
// Build option TEST_BYPASS_EN: adds the Test port. While Test = 1 the core
// reset follows nReset combinationally and the debounce threshold is one.

module pad_input_conditioner #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic            Clock,
  input  logic            nReset,
  output logic            nResetCore,
  input  logic [N_CH-1:0] nIn,
  output logic [N_CH-1:0] Level,
  output logic [N_CH-1:0] Press,
  output logic [N_CH-1:0] Release
`ifdef TEST_BYPASS_EN
  ,
  input  logic            Test
`endif
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  // ---------------------------------------------------------------------
  // Reset synchroniser
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic [SYNC_STAGES-1:0] rst_sync_d;
  logic                   bypass;

  always_comb begin
    rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

`ifdef TEST_BYPASS_EN
  // Scan needs direct pad control of the core reset.
  assign bypass     = Test;
  assign nResetCore = Test ? nReset : rst_sync_q[SYNC_STAGES-1];
`else
  assign bypass     = 1'b0;
  assign nResetCore = rst_sync_q[SYNC_STAGES-1];
`endif

  // ---------------------------------------------------------------------
  // Input channels
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [SYNC_STAGES-1:0] sync_d [N_CH];
  logic [CW-1:0]          cnt_q  [N_CH];
  logic [CW-1:0]          cnt_d  [N_CH];
  logic [N_CH-1:0]        sync_s;
  logic [N_CH-1:0]        level_q, level_d;
  logic [N_CH-1:0]        press_q, press_d;
  logic [N_CH-1:0]        release_q, release_d;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sync_s[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      sync_d[c] = {sync_q[c][SYNC_STAGES-2:0], nIn[c]};
      cnt_d[c]  = cnt_q[c];
      if (sync_s[c] == level_q[c]) begin
        // Any return to the stable level discards the partial count.
        cnt_d[c] = '0;
      end else if ((cnt_q[c] == CNT_MAX) || bypass) begin
        level_d[c]   = sync_s[c];
        cnt_d[c]     = '0;
        press_d[c]   = ~sync_s[c];
        release_d[c] = sync_s[c];
      end else begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge nResetCore) begin
    if (!nResetCore) begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= '1;
        cnt_q[c]  <= '0;
      end
      level_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= sync_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign Level   = level_q;
  assign Press   = press_q;
  assign Release = release_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
module tb_pad_input_conditioner;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       nResetCore;
  logic [3:0] nIn;
  logic [3:0] Level;
  logic [3:0] Press;
  logic [3:0] Release;
`ifdef TEST_BYPASS_EN
  logic       test;
`endif

  always #5 Clock = ~Clock;

  pad_input_conditioner #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .DEB_CYCLES(16)
  ) dut (
    .Clock(Clock),
    .nReset(nReset),
    .nResetCore(nResetCore),
    .nIn(nIn),
    .Level(Level),
    .Press(Press),
    .Release(Release)
`ifdef TEST_BYPASS_EN
    ,
    .Test(test)
`endif
  );

  typedef struct {
    logic [3:0] nin;
    int         hold;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  logic       mon_en = 1'b0;
  logic [3:0] press_seen = 4'b0;

  always @(negedge Clock) begin
    if (mon_en) press_seen = press_seen | Press;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    int press_edge;
    int core_edge;

    nReset = 1'b0;
    nIn    = 4'b1111;
`ifdef TEST_BYPASS_EN
    test   = 1'b0;
`endif

    // Reset release
    step(5);
    chk("rst_core_low", {3'b0, nResetCore}, 4'b0000);
    chk("rst_level", Level, 4'b1111);
    chk("rst_press", Press, 4'b0000);
    chk("rst_release", Release, 4'b0000);
    nReset = 1'b1;
    step(1);
    chk("rst_core_edge1", {3'b0, nResetCore}, 4'b0000);
    chk("rst_level_edge1", Level, 4'b1111);
    step(1);
    chk("rst_core_edge2", {3'b0, nResetCore}, 4'b0001);
    chk("rst_level_edge2", Level, 4'b1111);
    chk("rst_pulses_edge2", Press | Release, 4'b0000);
    step(3);

    // Vector table: apply nin, run hold edges, then compare.
    vecs.push_back('{4'b1110, 17, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1110,  1, 4'b1110, 4'b0001, 4'b0000});
    vecs.push_back('{4'b1110,  1, 4'b1110, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111, 17, 4'b1110, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111,  1, 4'b1111, 4'b0000, 4'b0001});
    vecs.push_back('{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 17, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000,  1, 4'b0000, 4'b1111, 4'b0000});
    vecs.push_back('{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111, 18, 4'b1111, 4'b0000, 4'b1111});
    vecs.push_back('{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000});
    // glitch window on channel 1 (entries 11..14)
    vecs.push_back('{4'b1101, 15, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1101, 15, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b1111,  4, 4'b1111, 4'b0000, 4'b0000});
    // staggered independent channels
    vecs.push_back('{4'b0111,  5, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0110, 13, 4'b0111, 4'b1000, 4'b0000});
    vecs.push_back('{4'b0110,  5, 4'b0110, 4'b0001, 4'b0000});
    vecs.push_back('{4'b1111, 18, 4'b1111, 4'b0000, 4'b1001});
    vecs.push_back('{4'b1111,  1, 4'b1111, 4'b0000, 4'b0000});

    for (int i = 0; i < vecs.size(); i++) begin
      mon_en = (i >= 11 && i <= 14);
      nIn = vecs[i].nin;
      step(vecs[i].hold);
      chk($sformatf("vec%0d_level", i), Level, vecs[i].lvl);
      chk($sformatf("vec%0d_press", i), Press, vecs[i].prs);
      chk($sformatf("vec%0d_release", i), Release, vecs[i].rel);
    end
    mon_en = 1'b0;
    chk("glitch_no_press", press_seen, 4'b0000);

    // Reset in the middle of a debounce on channel 2
    nIn = 4'b1011;
    step(10);
    chk("mid_level_before", Level, 4'b1111);
    nReset = 1'b0;
    #1;
    chk("mid_core_async", {3'b0, nResetCore}, 4'b0000);
    step(2);
    chk("mid_level_in_rst", Level, 4'b1111);
    chk("mid_press_in_rst", Press, 4'b0000);
    nReset = 1'b1;
    press_edge = 0;
    core_edge  = 0;
    for (int n = 1; n <= 40 && press_edge == 0; n++) begin
      step(1);
      if (core_edge == 0 && nResetCore === 1'b1) core_edge = n;
      if (Press[2] === 1'b1) press_edge = n;
      if (Press[1:0] !== 2'b00 || Press[3] !== 1'b0) press_edge = -n;
    end
    chk("mid_core_rise_edge", 4'(core_edge), 4'd2);
    checks++;
    if (press_edge != 20) begin
      failures++;
      $display("FAIL mid_press_edge actual=%0d expected=20", press_edge);
    end
    chk("mid_level_after", Level, 4'b1011);
    nIn = 4'b1111;
    step(20);

`ifdef TEST_BYPASS_EN
    test = 1'b1;
    nReset = 1'b0;
    #1;
    chk("byp_core_low", {3'b0, nResetCore}, 4'b0000);
    nReset = 1'b1;
    #1;
    chk("byp_core_high", {3'b0, nResetCore}, 4'b0001);
    nIn = 4'b1110;
    step(2);
    chk("byp_press_edge2", Press, 4'b0000);
    step(1);
    chk("byp_press_edge3", Press, 4'b0001);
    chk("byp_level_edge3", Level, 4'b1110);
    nIn = 4'b1111;
    step(4);
    test = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
